// File: rtl/bist_sequencer.sv
// bist_sequencer -- BIST session controller.
//
// Sequences a test pattern generator (TPG), an output response analyser
// (ORA) and a fault injection list (FIL). For each fault: TPG is held in
// reset for SETUP_CYCLES cycles, then patterns run until the ORA flags a
// detection (ora_res) or the TPG finishes (tpg_end). The fault is then
// counted as detected/undetected and the fault list is advanced. When the
// last fault has been run, the session ends in DONE.
//
// Parameters:
//   ERR_BITS     width of det_count / undet_count (saturating)
//   SETUP_CYCLES TPG reset cycles before each fault run, 1..255
//   TIMEOUT      watchdog limit in RUN cycles (BIST_TIMEOUT_EN builds only)
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        level, starts a session in IDLE or DONE
//   tpg_end      TPG emitted its last pattern
//   ora_res      ORA mismatch: current fault detected
//   fil_end      fault list is at its last entry
//   tpg_reset    holds TPG in reset
//   tpg_en       TPG advance enable
//   fil_inc      one-cycle pulse advancing the fault list
//   busy         session in progress (SETUP, RUN, ADV)
//   done         session finished
//   pass         valid with done: every fault was detected
//   det_count    detected-fault count
//   undet_count  undetected-fault count
//   timeout      (BIST_TIMEOUT_EN only) sticky watchdog flag, cleared on
//                start or reset
//
// Build option: define BIST_TIMEOUT_EN to add the RUN watchdog and the
// timeout port. Without it RUN waits indefinitely for ora_res/tpg_end.

module bist_sequencer #(
  parameter int unsigned ERR_BITS     = 8,
  parameter int unsigned SETUP_CYCLES = 3,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                tpg_end,
  input  logic                ora_res,
  input  logic                fil_end,
  output logic                tpg_reset,
  output logic                tpg_en,
  output logic                fil_inc,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_BITS-1:0] det_count,
  output logic [ERR_BITS-1:0] undet_count
`ifdef BIST_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 || TIMEOUT < 1) begin : g_param_check
    $error("bist_sequencer: SETUP_CYCLES must be 1..255 and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    ADV,
    DONE
  } state_t;

  // Setup counter counts down to zero, so it is loaded with one less than
  // the number of SETUP cycles wanted.
  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);

  state_t              state, state_d;
  logic [7:0]          setup_cnt, setup_cnt_d;
  logic [ERR_BITS-1:0] det_d, undet_d;

`ifdef BIST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  logic            timeout_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      setup_cnt   <= '0;
      det_count   <= '0;
      undet_count <= '0;
`ifdef BIST_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      setup_cnt   <= setup_cnt_d;
      det_count   <= det_d;
      undet_count <= undet_d;
`ifdef BIST_TIMEOUT_EN
      wd_cnt      <= wd_cnt_d;
      timeout     <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    setup_cnt_d = setup_cnt;
    det_d       = det_count;
    undet_d     = undet_count;
`ifdef BIST_TIMEOUT_EN
    // Held at zero outside RUN, so every RUN entry starts a fresh count.
    wd_cnt_d    = '0;
    timeout_d   = timeout;
`endif

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETUP;
          setup_cnt_d = SETUP_LOAD;
          det_d       = '0;
          undet_d     = '0;
`ifdef BIST_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (setup_cnt == '0) state_d = RUN;
        else                 setup_cnt_d = setup_cnt - 8'd1;
      end
      RUN: begin
`ifdef BIST_TIMEOUT_EN
        wd_cnt_d = wd_cnt + WD_W'(1);
`endif
        // A detection wins over tpg_end arriving in the same cycle.
        if (ora_res) begin
          state_d = ADV;
          if (det_count != '1) det_d = det_count + ERR_BITS'(1);
        end else if (tpg_end) begin
          state_d = ADV;
          if (undet_count != '1) undet_d = undet_count + ERR_BITS'(1);
        end
`ifdef BIST_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          state_d   = ADV;
          timeout_d = 1'b1;
          if (undet_count != '1) undet_d = undet_count + ERR_BITS'(1);
        end
`endif
      end
      ADV: begin
        if (fil_end) begin
          state_d = DONE;
        end else begin
          state_d     = SETUP;
          setup_cnt_d = SETUP_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    tpg_reset = (state != RUN);
    tpg_en    = (state == RUN);
    fil_inc   = (state == ADV);
    busy      = (state == SETUP) || (state == RUN) || (state == ADV);
    done      = (state == DONE);
    pass      = (state == DONE) && (undet_count == '0);
  end

endmodule

// File: tb/tb_bist_sequencer.sv
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, tpg_end = 1'b0, ora_res = 1'b0, fil_end = 1'b0;

  logic       tpg_reset, tpg_en, fil_inc, busy, done, pass;
  logic [7:0] det_count, undet_count;
  logic       s_tpg_reset, s_tpg_en, s_fil_inc, s_busy, s_done, s_pass;
  logic [1:0] s_det_count, s_undet_count;
`ifdef BIST_TIMEOUT_EN
  logic       timeout, s_timeout;
`endif

  int errors = 0;
  int checks = 0;
  int n_filinc = 0;

  always #5 clk = ~clk;

  bist_sequencer #(.ERR_BITS(8), .SETUP_CYCLES(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tpg_end(tpg_end),
    .ora_res(ora_res), .fil_end(fil_end), .tpg_reset(tpg_reset),
    .tpg_en(tpg_en), .fil_inc(fil_inc), .busy(busy), .done(done),
    .pass(pass), .det_count(det_count), .undet_count(undet_count)
`ifdef BIST_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  bist_sequencer #(.ERR_BITS(2), .SETUP_CYCLES(3), .TIMEOUT(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .tpg_end(tpg_end),
    .ora_res(ora_res), .fil_end(fil_end), .tpg_reset(s_tpg_reset),
    .tpg_en(s_tpg_en), .fil_inc(s_fil_inc), .busy(s_busy), .done(s_done),
    .pass(s_pass), .det_count(s_det_count), .undet_count(s_undet_count)
`ifdef BIST_TIMEOUT_EN
    , .timeout(s_timeout)
`endif
  );

  // in  = {rst_n, start, ora_res, tpg_end, fil_end} applied before the edge
  // out = {tpg_reset, tpg_en, fil_inc, busy, done, pass} expected after it
  typedef struct packed {
    logic [4:0] in;
    logic [5:0] out;
    logic [7:0] det;
    logic [7:0] undet;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (fil_inc === 1'b1) n_filinc++;
  endtask

  task automatic do_reset();
    {rst_n, start, ora_res, tpg_end, fil_end} = 5'b00000;
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until tpg_en rises; returns the number of edges taken.
  task automatic wait_run(output int n);
    n = 0;
    while (tpg_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;

    //               rst,st,ora,te,fe   tr te fi b d p
    tbl[0]  = '{5'b00000, 6'b100000, 8'd0, 8'd0};  // reset
    tbl[1]  = '{5'b10000, 6'b100000, 8'd0, 8'd0};  // idle
    tbl[2]  = '{5'b11000, 6'b100100, 8'd0, 8'd0};  // start -> SETUP
    tbl[3]  = '{5'b10010, 6'b100100, 8'd0, 8'd0};  // tpg_end ignored in SETUP
    tbl[4]  = '{5'b11000, 6'b100100, 8'd0, 8'd0};  // start ignored in SETUP
    tbl[5]  = '{5'b10000, 6'b010100, 8'd0, 8'd0};  // RUN after 3 setup cycles
    tbl[6]  = '{5'b10000, 6'b010100, 8'd0, 8'd0};
    tbl[7]  = '{5'b10010, 6'b101100, 8'd0, 8'd1};  // tpg_end -> ADV, undet
    tbl[8]  = '{5'b10000, 6'b100100, 8'd0, 8'd1};  // not last -> SETUP
    tbl[9]  = '{5'b10000, 6'b100100, 8'd0, 8'd1};
    tbl[10] = '{5'b10000, 6'b100100, 8'd0, 8'd1};
    tbl[11] = '{5'b10000, 6'b010100, 8'd0, 8'd1};
    tbl[12] = '{5'b10110, 6'b101100, 8'd1, 8'd1};  // ora+tpg_end -> detected only
    tbl[13] = '{5'b10000, 6'b100100, 8'd1, 8'd1};
    tbl[14] = '{5'b10000, 6'b100100, 8'd1, 8'd1};
    tbl[15] = '{5'b10000, 6'b100100, 8'd1, 8'd1};
    tbl[16] = '{5'b10000, 6'b010100, 8'd1, 8'd1};
    tbl[17] = '{5'b10010, 6'b101100, 8'd1, 8'd2};
    tbl[18] = '{5'b10001, 6'b100010, 8'd1, 8'd2};  // last fault -> DONE, pass=0
    tbl[19] = '{5'b10100, 6'b100010, 8'd1, 8'd2};  // ora ignored in DONE
    tbl[20] = '{5'b11000, 6'b100100, 8'd0, 8'd0};  // restart clears counters
    tbl[21] = '{5'b00000, 6'b100000, 8'd0, 8'd0};  // reset from SETUP

    for (int i = 0; i < 22; i++) begin
      {rst_n, start, ora_res, tpg_end, fil_end} = tbl[i].in;
      tick();
      chk($sformatf("v%0d_outs", i), {tpg_reset, tpg_en, fil_inc, busy, done, pass}, tbl[i].out);
      chk($sformatf("v%0d_det", i), det_count, tbl[i].det);
      chk($sformatf("v%0d_undet", i), undet_count, tbl[i].undet);
    end

    // Three faults, each detected on the 5th RUN cycle.
    do_reset();
    n_filinc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_run(n);
      chk("a_setup_len", n, 3);
      repeat (4) tick();
      chk("a_run5_en", tpg_en, 1'b1);
      ora_res = 1'b1;
      tick();
      ora_res = 1'b0;
      chk("a_adv_inc", fil_inc, 1'b1);
      chk("a_adv_det", det_count, f + 1);
      fil_end = (f == 2);
      tick();
      fil_end = 1'b0;
    end
    chk("a_done", {done, pass, busy, tpg_en}, 4'b1100);
    chk("a_det", det_count, 3);
    chk("a_undet", undet_count, 0);
    repeat (2) tick();
    chk("a_filinc_pulses", n_filinc, 3);
    chk("a_done_hold", {done, pass}, 2'b11);

    // Reset mid-RUN, then reset during the ADV pulse.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run(n);
    ora_res = 1'b1;
    tick();
    ora_res = 1'b0;
    tick();
    wait_run(n);
    tick();
    chk("b_pre_det", det_count, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("b_rst_outs", {tpg_reset, tpg_en, fil_inc, busy, done, pass}, 6'b100000);
    chk("b_rst_cnt", {det_count, undet_count}, 16'd0);
    tick();
    chk("b_rst_idle", {tpg_reset, busy}, 2'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run(n);
    tpg_end = 1'b1;
    tick();
    tpg_end = 1'b0;
    chk("b_adv", fil_inc, 1'b1);
    n_filinc = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("b_no_pulse", n_filinc, 0);
    chk("b_adv_rst_state", {busy, undet_count}, 9'd0);

    // Saturation: five detected faults on a 2-bit counter.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 5; f++) begin
      wait_run(n);
      ora_res = 1'b1;
      tick();
      ora_res = 1'b0;
      fil_end = (f == 4);
      tick();
      fil_end = 1'b0;
    end
    chk("c_sat_det", s_det_count, 3);
    chk("c_wide_det", det_count, 5);
    chk("c_sat_done", {s_done, s_pass}, 2'b11);

`ifdef BIST_TIMEOUT_EN
    // Watchdog: no response for TIMEOUT=16 RUN cycles.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run(n);
    repeat (15) tick();
    chk("d_run15", {tpg_en, timeout}, 2'b10);
    tick();
    chk("d_to_adv", {fil_inc, timeout}, 2'b11);
    chk("d_to_undet", undet_count, 1);
    fil_end = 1'b1;
    tick();
    fil_end = 1'b0;
    chk("d_to_done", {done, pass, timeout}, 3'b101);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_to_clear", timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
